regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Arbiter and scheduler for the single register-file write port (we/wa3/wd3).
//  Shares the port between N writeback requesters (ALU, load unit, CSR/mul, ...)
//    with valid/ready handshakes and round-robin fairness.
//  Drives the write port from a register stage.
//  Optionally keeps a per-register pending-write scoreboard that decode uses to stall.
// PARAMETERS
//  N_REQ    2   number of writeback requesters, 2..4
//  XLEN     32  write data width
//  ADDR_W   5   register address width (32 architectural regs, x0 hardwired zero)
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             synchronous, active-high reset
//  req_valid   in   N_REQ         requester i has a write pending
//  req_ready   out  N_REQ         grant: requester i's write is accepted this cycle
//  req_addr    in   N_REQ*ADDR_W  dest register, requester i at [i*ADDR_W +: ADDR_W]
//  req_data    in   N_REQ*XLEN    write data, requester i at [i*XLEN +: XLEN]
//  rf_we       out  1             to register file we
//  rf_wa       out  ADDR_W        to register file wa3
//  rf_wd       out  XLEN          to register file wd3
//  claim_valid in   1             issue stage reserves claim_addr as a pending destination
//  claim_addr  in   ADDR_W        register being reserved
//  busy        out  2**ADDR_W     bit r = write to x<r> outstanding; bit 0 always 0
// BEHAVIOUR
//  - Reset (rst=1 at posedge): rf_we=0, rf_wa=0, rf_wd=0, busy=0, rr pointer=0.
//    req_ready is forced all-0 while rst=1.
//    An in-flight accepted write whose rf_we has not yet issued is dropped.
//  - Grant (combinational): start at rr pointer p, scan p, p+1, ... mod N_REQ.
//    The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
//    At most one ready bit is set. No valid -> no ready.
//  - Handshake: transfer when valid & ready. A requester holds valid, addr and data
//    stable until ready. The arbiter never depends on ready before valid.
//  - Pointer: on a transfer by i, p <= (i+1) mod N_REQ. No transfer -> p unchanged.
//    Worst-case wait for a continuously valid requester is N_REQ-1 grants.
//  - Latency: write accepted in cycle T -> rf_we=1 with rf_wa/rf_wd in cycle T+1.
//    The register file commits at the end of T+1.
//    Back-to-back accepts give one write per cycle. No bubble is required.
//  - Cycle with no transfer: rf_we <= 0. rf_wa and rf_wd hold their last values.
//  - x0 target: the handshake completes normally, but rf_we <= 0 (write discarded).
//  - Same-address writes from different requesters in consecutive cycles commit in
//    grant order. The last grant wins.
// CONFIGURATION
//  RFWB_SCOREBOARD_EN defined:
//   - claim_valid & claim_addr!=0 sets busy[claim_addr] at the next edge.
//   - A cycle with rf_we=1 clears busy[rf_wa] at the next edge.
//   - Set and clear of the same register in one cycle: set wins.
//     This reflects a new producer issued while the old write commits.
//   - busy[0] is always 0. A claim of x0 is ignored.
//  RFWB_SCOREBOARD_EN undefined:
//   - claim_* are ignored and busy is tied to 0.
//   - No scoreboard flops are synthesised.
// STRUCTURE
//  - Shared package regfile_pkg holds: XLEN, REG_ADDR_W, NUM_REGS (=2**REG_ADDR_W),
//    REG_ZERO (=0), and the typedefs reg_addr_t and xdata_t.
//  - Sub-module rr_arbiter holds the pointer register and the rotate/priority-encode logic.
//    Its outputs are a one-hot grant and a grant index; its inputs are req and advance.
//  - The top level contains the write-port register stage and the scoreboard generate block.
// TESTING
//  1. Reset: hold rst 3 cycles with all req_valid=1.
//     -> req_ready=0, rf_we=0, busy=0 throughout.
//     First cycle after release -> req_ready=01 (p=0).
//  2. Contention: N_REQ=2, both valid for 4 cycles. req0=(x5,0xA), req1=(x6,0xB).
//     -> grants alternate 0,1,0,1.
//     -> rf_we=1 every cycle from the 2nd onward, rf_wa=5,6,5,6.
//  3. x0 write: req1=(x0,0xDEAD) valid alone.
//     -> req_ready[1]=1 for one cycle; next cycle rf_we=0; pointer advances to 0.
//  4. Single requester: req0 valid 1 cycle with (x31,0x1234).
//     -> next cycle rf_we=1, rf_wa=31, rf_wd=0x1234; following cycle rf_we=0.
//  5. Scoreboard (EN): claim x7 -> busy[7]=1. Then write x7 -> busy[7] clears the cycle
//     after rf_we. Claim x7 in the same cycle as rf_we on x7 -> busy[7] stays 1.
//  6. Reset mid-operation: accept req0 (x9) then assert rst.
//     -> rf_we=0 the next cycle; busy=0. With EN undefined, busy=0 always.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: data width, register address width,
// register count, the hardwired-zero register index and the matching typedefs.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority scan starting at the pointer,
// producing a one-hot grant and its index. The pointer moves to one past the
// granted requester whenever the caller reports that the grant was taken.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan req starting at the pointer (mod N); first set bit wins.
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

  // Next pointer: one past the granted requester, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (gnt_idx == IDX_W'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between
// N_REQ valid/ready requesters with round-robin fairness, registers the
// selected write onto rf_we/rf_wa/rf_wd one cycle after acceptance, and
// drops writes to x0.
// Optional pending-write scoreboard enabled by defining RFWB_SCOREBOARD_EN;
// without it claim_* are ignored and busy is tied to zero.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 2,
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_wa,
  output logic [XLEN-1:0]         rf_wd,
  input  logic                    claim_valid,
  input  logic [ADDR_W-1:0]       claim_addr,
  output logic [2**ADDR_W-1:0]    busy
);

  import regfile_pkg::*;

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [XLEN-1:0]   wd_q, wd_d;

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No grant is visible while in reset, so nothing can be accepted then.
  assign req_ready = rst ? '0 : gnt;
  assign xfer      = |req_ready;

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Write-port next state: x0 targets complete the handshake but never assert we.
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (xfer) begin
      we_d = (sel_addr != ZERO_ADDR);
      wa_d = sel_addr;
      wd_d = sel_data;
    end
  end

  // Write-port register stage; reset drops any write not yet issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign rf_we = we_q;
  assign rf_wa = wa_q;
  assign rf_wd = wd_q;

`ifdef RFWB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] busy_q, busy_d;

  // Clear on commit, then set on claim so a new producer outranks the old write.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (claim_valid && (claim_addr != ZERO_ADDR)) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_claim;
  assign unused_claim = ^{claim_valid, claim_addr};
  assign busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (N_REQ=2): reset, a directed
// vector table, hand sequences for reset/scoreboard corners, then random
// traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N  = 2;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*XL-1:0]   req_data;
  logic              rf_we;
  logic [AW-1:0]     rf_wa;
  logic [XL-1:0]     rf_wd;
  logic              claim_valid;
  logic [AW-1:0]     claim_addr;
  logic [NR-1:0]     busy;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: what the write port and scoreboard should show now.
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_busy;
  logic [N-1:0] last_acc;
  int          cur_g;

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic at_neg();
    logic [N-1:0] er;
    @(negedge clk);
    cur_g = model_grant();
    er = '0;
    if (cur_g >= 0) er[cur_g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rf_we", rf_we, m_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
    chk("busy", busy, m_busy);
  endtask

  task automatic at_pos();
    logic [31:0] nb;
    @(posedge clk);
    if (rst) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0; m_ptr = 0; last_acc = '0;
    end else begin
      nb = m_busy;
`ifdef RFWB_SCOREBOARD_EN
      if (m_we) nb[m_wa] = 1'b0;
      if (claim_valid && claim_addr != 5'd0) nb[claim_addr] = 1'b1;
`else
      nb = '0;
`endif
      last_acc = '0;
      if (cur_g >= 0) begin
        m_wa  = req_addr[cur_g*AW +: AW];
        m_wd  = req_data[cur_g*XL +: XL];
        m_we  = (m_wa != 5'd0);
        m_ptr = (cur_g + 1) % N;
        last_acc[cur_g] = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      m_busy = nb;
    end
    #1;
  endtask

  task automatic tick();
    at_neg();
    at_pos();
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*XL +: XL] = d;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic        we;
    logic        chk_wd;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // contention x5/0xA vs x6/0xB, then x0 write, then single write to x31
    tbl[0] = '{2'b11, 5'd5, 32'hA, 5'd6, 32'hB, 2'b01, 1'b0, 1'b1, 5'd0, 32'h0};
    tbl[1] = '{2'b11, 5'd5, 32'hA, 5'd6, 32'hB, 2'b10, 1'b1, 1'b1, 5'd5, 32'hA};
    tbl[2] = '{2'b11, 5'd5, 32'hA, 5'd6, 32'hB, 2'b01, 1'b1, 1'b1, 5'd6, 32'hB};
    tbl[3] = '{2'b11, 5'd5, 32'hA, 5'd6, 32'hB, 2'b10, 1'b1, 1'b1, 5'd5, 32'hA};
    tbl[4] = '{2'b00, 5'd5, 32'hA, 5'd6, 32'hB, 2'b00, 1'b1, 1'b1, 5'd6, 32'hB};
    tbl[5] = '{2'b10, 5'd0, 32'h0, 5'd0, 32'hDEAD, 2'b10, 1'b0, 1'b1, 5'd6, 32'hB};
    tbl[6] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'hDEAD, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[7] = '{2'b01, 5'd31, 32'h1234, 5'd0, 32'h0, 2'b01, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[8] = '{2'b00, 5'd31, 32'h1234, 5'd0, 32'h0, 2'b00, 1'b1, 1'b1, 5'd31, 32'h1234};
    tbl[9] = '{2'b00, 5'd31, 32'h1234, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1, 5'd31, 32'h1234};

    m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0; m_busy = '0; last_acc = '0; cur_g = -1;
    rst = 1'b1; claim_valid = 1'b0; claim_addr = '0;
    req_valid = '1; req_addr = '0; req_data = '0;
    @(posedge clk); #1;

    // Reset held with every requester valid: nothing granted, outputs quiet.
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("rst_ready", req_ready, 2'b00);
      at_pos();
    end
    rst = 1'b0;

    // Directed vector table.
    for (int r = 0; r < 10; r++) begin
      set_req(0, tbl[r].v[0], tbl[r].a0, tbl[r].d0);
      set_req(1, tbl[r].v[1], tbl[r].a1, tbl[r].d1);
      at_neg();
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
      chk($sformatf("tbl%0d_we", r), rf_we, tbl[r].we);
      if (tbl[r].chk_wd) begin
        chk($sformatf("tbl%0d_wa", r), rf_wa, tbl[r].wa);
        chk($sformatf("tbl%0d_wd", r), rf_wd, tbl[r].wd);
      end
      at_pos();
    end

`ifdef RFWB_SCOREBOARD_EN
    // Claim x7, commit x7, then claim x7 again during its commit cycle.
    claim_valid = 1'b1; claim_addr = 5'd7;
    tick();
    claim_valid = 1'b0;
    at_neg(); chk("sb_claim", busy[7], 1'b1); at_pos();
    set_req(0, 1'b1, 5'd7, 32'h77);
    tick();
    set_req(0, 1'b0, 5'd7, 32'h77);
    at_neg(); chk("sb_we7", rf_we, 1'b1); chk("sb_still", busy[7], 1'b1); at_pos();
    at_neg(); chk("sb_clear", busy[7], 1'b0); at_pos();
    claim_valid = 1'b1; claim_addr = 5'd7;
    tick();
    claim_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h78);
    tick();
    set_req(0, 1'b0, 5'd7, 32'h78);
    claim_valid = 1'b1; claim_addr = 5'd7;
    at_neg(); chk("sb_we7b", rf_we, 1'b1); at_pos();
    claim_valid = 1'b0;
    at_neg(); chk("sb_setwins", busy[7], 1'b1); at_pos();
    claim_valid = 1'b1; claim_addr = 5'd0;
    tick();
    claim_valid = 1'b0;
    at_neg(); chk("sb_x0", busy[0], 1'b0); at_pos();
`endif

    // Reset right after accepting a write to x9.
    set_req(0, 1'b1, 5'd9, 32'h99);
    claim_valid = 1'b1; claim_addr = 5'd9;
    tick();
    set_req(0, 1'b0, 5'd9, 32'h99);
    claim_valid = 1'b0;
    rst = 1'b1;
    at_neg(); chk("mid_we", rf_we, 1'b1); chk("mid_wa", rf_wa, 5'd9); at_pos();
    rst = 1'b0;
    at_neg(); chk("post_rst_we", rf_we, 1'b0); chk("post_rst_busy", busy, 32'h0); at_pos();

    // Random traffic: requesters hold their request until it is accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          set_req(i, 1'($urandom % 2), 5'($urandom % 32), $urandom);
        end
      end
      claim_valid = ($urandom % 3) == 0;
      claim_addr  = 5'($urandom % 32);
      rst         = ($urandom % 64) == 0;
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
